// File: rtl/cp0_reg_if.sv
// CP0 register-file port bundle: WB write port, EX read port, exception commit
// inputs and register snapshots.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, data_i, raddr_i, int_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
           config_o, prid_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, data_i, raddr_i, int_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o,
           config_o, prid_o, timer_int_o
  );
endinterface

// File: rtl/cp0_reg.sv
// MIPS32 coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC,
// read-only PRId/Config, and exception/ERET side effects from the memory stage.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input logic clk,
  input logic rst,
  cp0_reg_if.slave bus
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;
  localparam logic [4:0] ADDR_CONFIG  = 5'd16;

  logic [31:0] count_q, compare_q, status_q, cause_q, epc_q;
  logic        timer_int_q;

  logic [31:0] count_n, compare_n, status_n, cause_n, epc_n;
  logic        timer_int_n;
  logic        exc_valid, eret, exl_before;
  logic [4:0]  exc_code;

  always_comb begin
    exc_valid = 1'b1;
    exc_code  = 5'h00;
    eret      = 1'b0;
    case (bus.excepttype_i)
      32'h0000_0001: exc_code = 5'h00;
      32'h0000_0008: exc_code = 5'h08;
      32'h0000_000A: exc_code = 5'h0A;
      32'h0000_000D: exc_code = 5'h0D;
      32'h0000_000C: exc_code = 5'h0C;
      32'h0000_000E: begin
        exc_valid = 1'b0;
        eret      = 1'b1;
      end
      default:       exc_valid = 1'b0;
    endcase
  end

  // Software write first, then exception/ERET overrides the fields it owns.
  always_comb begin
    count_n     = count_q + 32'd1;
    compare_n   = compare_q;
    status_n    = status_q;
    cause_n     = cause_q;
    epc_n       = epc_q;
    timer_int_n = timer_int_q;

    cause_n[15:10] = bus.int_i;

    if ((compare_q != 32'd0) && (count_q == compare_q))
      timer_int_n = 1'b1;

    if (bus.we_i) begin
      case (bus.waddr_i)
        ADDR_COUNT:   count_n = bus.data_i;
        ADDR_COMPARE: begin
          compare_n   = bus.data_i;
          timer_int_n = 1'b0;
        end
        ADDR_STATUS:  status_n = bus.data_i;
        ADDR_CAUSE: begin
          cause_n[9:8]   = bus.data_i[9:8];
          cause_n[23:22] = bus.data_i[23:22];
        end
        ADDR_EPC:     epc_n = bus.data_i;
        default:      ;
      endcase
    end

    exl_before = status_n[1];
    if (exc_valid) begin
      if (!exl_before) begin
        epc_n       = bus.is_in_delayslot_i ? (bus.current_inst_addr_i - 32'd4)
                                            : bus.current_inst_addr_i;
        cause_n[31] = bus.is_in_delayslot_i;
      end
      status_n[1]   = 1'b1;
      cause_n[6:2]  = exc_code;
    end else if (eret) begin
      status_n[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      status_q    <= STATUS_RESET;
      cause_q     <= 32'd0;
      epc_q       <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_n;
      compare_q   <= compare_n;
      status_q    <= status_n;
      cause_q     <= cause_n;
      epc_q       <= epc_n;
      timer_int_q <= timer_int_n;
    end
  end

  always_comb begin
    bus.data_o = 32'd0;
    case (bus.raddr_i)
      ADDR_COUNT:   bus.data_o = count_q;
      ADDR_COMPARE: bus.data_o = compare_q;
      ADDR_STATUS:  bus.data_o = status_q;
      ADDR_CAUSE:   bus.data_o = cause_q;
      ADDR_EPC:     bus.data_o = epc_q;
      ADDR_PRID:    bus.data_o = PRID_VALUE;
      ADDR_CONFIG:  bus.data_o = CONFIG_VALUE;
      default:      bus.data_o = 32'd0;
    endcase
  end

  assign bus.count_o     = count_q;
  assign bus.compare_o   = compare_q;
  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.config_o    = CONFIG_VALUE;
  assign bus.prid_o      = PRID_VALUE;
  assign bus.timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: timer, wrap, exceptions, ERET, Cause write mask.
module tb_cp0_reg;
  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fails;

  cp0_reg_if bus();

  cp0_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.we_i    = 1'b1;
    bus.waddr_i = addr;
    bus.data_i  = data;
    @(posedge clk);
    #1;
    bus.we_i    = 1'b0;
  endtask

  task automatic exc(input logic [31:0] etype, input logic [31:0] pc, input logic ds);
    @(negedge clk);
    bus.excepttype_i        = etype;
    bus.current_inst_addr_i = pc;
    bus.is_in_delayslot_i   = ds;
    @(posedge clk);
    #1;
    bus.excepttype_i      = 32'd0;
    bus.is_in_delayslot_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    n_asserts = 0;
    n_fails   = 0;
    rst = 1'b0;
    bus.we_i = 1'b0;
    bus.waddr_i = 5'd0;
    bus.data_i = 32'd0;
    bus.raddr_i = 5'd16;
    bus.int_i = 6'd0;
    bus.excepttype_i = 32'd0;
    bus.current_inst_addr_i = 32'd0;
    bus.is_in_delayslot_i = 1'b0;

    #12;
    check("rst_count", bus.count_o, 32'd0);
    check("rst_status", bus.status_o, 32'h10000000);
    check("rst_cause", bus.cause_o, 32'd0);
    check("rst_epc", bus.epc_o, 32'd0);
    check("rst_timer", {31'd0, bus.timer_int_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(5);
    check("count_after_5", bus.count_o, 32'd5);
    check("status_after_5", bus.status_o, 32'h10000000);
    check("prid_value", bus.prid_o, 32'h004C0102);
    check("config_read", bus.data_o, 32'h00008000);

    // Timer match and clear
    wr(5'd11, 32'd20);
    check("compare_loaded", bus.compare_o, 32'd20);
    wr(5'd9, 32'd15);
    check("count_loaded", bus.count_o, 32'd15);
    guard = 0;
    while (bus.count_o != 32'd20 && guard < 50) begin
      cycles(1);
      guard++;
    end
    check("count_reached_20", bus.count_o, 32'd20);
    check("timer_before_edge", {31'd0, bus.timer_int_o}, 32'd0);
    cycles(1);
    check("timer_rise", {31'd0, bus.timer_int_o}, 32'd1);
    cycles(3);
    check("timer_sticky", {31'd0, bus.timer_int_o}, 32'd1);
    wr(5'd11, 32'd100);
    check("timer_cleared", {31'd0, bus.timer_int_o}, 32'd0);

    // Re-arm, then async reset mid-cycle
    wr(5'd9, 32'd98);
    cycles(3);
    check("timer_rearm", {31'd0, bus.timer_int_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_timer", {31'd0, bus.timer_int_o}, 32'd0);
    check("async_rst_count", bus.count_o, 32'd0);
    check("async_rst_compare", bus.compare_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Count wrap with Compare=0
    wr(5'd9, 32'hFFFFFFFE);
    cycles(2);
    check("count_wrap", bus.count_o, 32'd0);
    cycles(1);
    check("no_timer_cmp0", {31'd0, bus.timer_int_o}, 32'd0);

    // Exceptions
    exc(32'h8, 32'hBFC00100, 1'b1);
    check("exc1_epc", bus.epc_o, 32'hBFC000FC);
    check("exc1_bd", {31'd0, bus.cause_o[31]}, 32'd1);
    check("exc1_code", {27'd0, bus.cause_o[6:2]}, 32'h08);
    check("exc1_exl", {31'd0, bus.status_o[1]}, 32'd1);
    exc(32'hC, 32'h80000020, 1'b0);
    check("exc2_epc_kept", bus.epc_o, 32'hBFC000FC);
    check("exc2_code", {27'd0, bus.cause_o[6:2]}, 32'h0C);
    check("exc2_bd_kept", {31'd0, bus.cause_o[31]}, 32'd1);

    // Status write with ERET in the same cycle
    @(negedge clk);
    bus.we_i = 1'b1;
    bus.waddr_i = 5'd12;
    bus.data_i = 32'h0000FF03;
    bus.excepttype_i = 32'hE;
    @(posedge clk);
    #1;
    bus.we_i = 1'b0;
    bus.excepttype_i = 32'd0;
    check("eret_status", bus.status_o, 32'h0000FF01);
    bus.raddr_i = 5'd12;
    #1;
    check("status_read", bus.data_o, 32'h0000FF01);

    // Cause write mask and read-only PRId
    do_reset();
    bus.int_i = 6'b000101;
    wr(5'd13, 32'hFFFFFFFF);
    check("cause_mask", bus.cause_o, 32'h00C01700);
    wr(5'd15, 32'h12345678);
    check("prid_ro", bus.prid_o, 32'h004C0102);
    bus.raddr_i = 5'd15;
    #1;
    check("prid_read", bus.data_o, 32'h004C0102);
    wr(5'd3, 32'hDEADBEEF);
    bus.raddr_i = 5'd3;
    #1;
    check("unmapped_read", bus.data_o, 32'd0);
    bus.raddr_i = 5'd14;
    #1;
    check("epc_read_rst", bus.data_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
